conv2d_engine: RTL and testbench

Parametrised 2-D convolution engine that succeeds the fixed 3-channel-in / 7-channel-out 28×28 convolution top. It computes one output feature map per output channel from an external feature memory and weight memory. Kernel size, stride and zero-padding are configurable, and results stream out over a valid/ready handshake with backpressure. It sits between the input feature RAM / weight ROM and the pooling or write-back stage of the CNN pipeline.

---
 rtl/conv_pkg.sv | 31 +++
 rtl/conv_mac.sv | 35 +++
 rtl/conv2d_engine.sv | 184 ++++++++++++++++++
 tb/tb_conv2d_engine.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv2d_engine slice: FSM state codes, geometry helpers
// and width checks. Optional feature macro used by the engine: CONV_RELU_EN.
package conv_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_MAC   = 3'd1;
  localparam state_t S_DRAIN = 3'd2;
  localparam state_t S_OUT   = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  // Address/counter width for a range of n entries, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int out_dim(input int h, input int k, input int stride, input int pad);
    return (h + 2 * pad - k) / stride + 1;
  endfunction

  function automatic bit acc_width_ok(input int aw, input int dw, input int ww, input int taps);
    return aw >= dw + ww + $clog2(taps);
  endfunction

  // Widths of the legacy 3-in / 7-out 28x28 3x3 layer.
  localparam int FM_AW_DEFAULT  = addr_w(3 * 28 * 28);
  localparam int WT_AW_DEFAULT  = addr_w(7 * 3 * 3 * 3);
  localparam int OUT_AW_DEFAULT = addr_w(7 * 26 * 26);

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate for one output pixel; the pad flag zeroes the feature operand.
// sum is the accumulator value including the tap presented this cycle.
module conv_mac #(
  parameter int DW = 8,
  parameter int WW = 8,
  parameter int AW = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tap_valid,
  input  logic                 tap_first,
  input  logic                 tap_pad,
  input  logic signed [DW-1:0] fm_data,
  input  logic signed [WW-1:0] wt_data,
  output logic signed [AW-1:0] sum
);

  logic signed [DW-1:0]    fop;
  logic signed [DW+WW-1:0] prod;
  logic signed [AW-1:0]    acc;

  always_comb begin
    fop  = tap_pad ? '0 : fm_data;
    prod = $signed({{WW{fop[DW-1]}}, fop}) * $signed({{DW{wt_data[WW-1]}}, wt_data});
    sum  = acc;
    if (tap_valid)
      sum = (tap_first ? '0 : acc) + {{(AW-DW-WW){prod[DW+WW-1]}}, prod};
  end

  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else     acc <= sum;
  end

endmodule

// File: rtl/conv2d_engine.sv
// Parametrised 2-D convolution engine: address generation, tap sequencing and result handshake.
// Define CONV_RELU_EN to clamp negative results to zero.
module conv2d_engine
  import conv_pkg::*;
#(
  parameter int DW     = 8,
  parameter int WW     = 8,
  parameter int AW     = 24,
  parameter int H      = 28,
  parameter int W      = 28,
  parameter int IC     = 3,
  parameter int OC     = 7,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int PAD    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [addr_w(IC*H*W)-1:0] fm_addr,
  input  logic signed [DW-1:0] fm_rdata,
  output logic [addr_w(OC*IC*K*K)-1:0] wt_addr,
  input  logic signed [WW-1:0] wt_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [AW-1:0] out_data,
  output logic [addr_w(OC*out_dim(H,K,STRIDE,PAD)*out_dim(W,K,STRIDE,PAD))-1:0] out_addr
);

  localparam int OH  = out_dim(H, K, STRIDE, PAD);
  localparam int OW  = out_dim(W, K, STRIDE, PAD);
  localparam int N   = IC * K * K;
  localparam int FAW = addr_w(IC * H * W);
  localparam int WAW = addr_w(OC * IC * K * K);
  localparam int OAW = addr_w(OC * OH * OW);
  localparam int OCW = addr_w(OC);
  localparam int OYW = addr_w(OH);
  localparam int OXW = addr_w(OW);
  localparam int ICW = addr_w(IC);
  localparam int KW  = addr_w(K);

  localparam logic [OCW-1:0] OC_LAST = OCW'(OC - 1);
  localparam logic [OYW-1:0] OY_LAST = OYW'(OH - 1);
  localparam logic [OXW-1:0] OX_LAST = OXW'(OW - 1);
  localparam logic [ICW-1:0] IC_LAST = ICW'(IC - 1);
  localparam logic [KW-1:0]  K_LAST  = KW'(K - 1);

  if (!acc_width_ok(AW, DW, WW, N)) begin : g_bad_acc_width
    $error("conv2d_engine: AW is narrower than DW+WW+clog2(IC*K*K)");
  end
  if (STRIDE < 1 || PAD >= K) begin : g_bad_geometry
    $error("conv2d_engine: STRIDE must be >= 1 and PAD < K");
  end

  state_t state, n_state;
  logic [OCW-1:0] oc, n_oc;
  logic [OYW-1:0] oy, n_oy;
  logic [OXW-1:0] ox, n_ox;
  logic [ICW-1:0] ic, n_ic;
  logic [KW-1:0]  ky, n_ky, kx, n_kx;
  logic           load, tap_last, pix_last;
  logic           tap_pad, n_pad, v_d, pad_d, first_d;
  int             iy, ix;
  logic [FAW-1:0] fm_next;
  logic [WAW-1:0] wt_next;
  logic [OAW-1:0] pix_addr;
  logic signed [AW-1:0] mac_sum, result;

  assign tap_last  = (ic == IC_LAST) && (ky == K_LAST) && (kx == K_LAST);
  assign pix_last  = (oc == OC_LAST) && (oy == OY_LAST) && (ox == OX_LAST);
  assign busy      = (state == S_MAC) || (state == S_DRAIN) || (state == S_OUT);
  assign done      = (state == S_DONE);
  assign out_valid = (state == S_OUT);

  // Counters name the tap being issued; load marks an edge that presents a new tap's addresses.
  always_comb begin
    n_state = state;
    load    = 1'b0;
    n_oc = oc; n_oy = oy; n_ox = ox;
    n_ic = ic; n_ky = ky; n_kx = kx;
    case (state)
      S_IDLE: if (start) begin
        n_state = S_MAC;
        load    = 1'b1;
        n_oc = '0; n_oy = '0; n_ox = '0;
        n_ic = '0; n_ky = '0; n_kx = '0;
      end
      S_MAC: if (tap_last) n_state = S_DRAIN;
      else begin
        load = 1'b1;
        if (kx != K_LAST) n_kx = kx + 1'b1;
        else begin
          n_kx = '0;
          if (ky != K_LAST) n_ky = ky + 1'b1;
          else begin
            n_ky = '0;
            n_ic = ic + 1'b1;
          end
        end
      end
      S_DRAIN: n_state = S_OUT;
      S_OUT: if (out_ready) begin
        if (pix_last) n_state = S_DONE;
        else begin
          n_state = S_MAC;
          load    = 1'b1;
          n_ic = '0; n_ky = '0; n_kx = '0;
          if (ox != OX_LAST) n_ox = ox + 1'b1;
          else begin
            n_ox = '0;
            if (oy != OY_LAST) n_oy = oy + 1'b1;
            else begin
              n_oy = '0;
              n_oc = oc + 1'b1;
            end
          end
        end
      end
      S_DONE:  n_state = S_IDLE;
      default: n_state = S_IDLE;
    endcase
  end

  always_comb begin
    iy       = int'(n_oy) * STRIDE + int'(n_ky) - PAD;
    ix       = int'(n_ox) * STRIDE + int'(n_kx) - PAD;
    n_pad    = (iy < 0) || (iy >= H) || (ix < 0) || (ix >= W);
    fm_next  = FAW'((int'(n_ic) * H + iy) * W + ix);
    wt_next  = WAW'(((int'(n_oc) * IC + int'(n_ic)) * K + int'(n_ky)) * K + int'(n_kx));
    pix_addr = OAW'((int'(oc) * OH + int'(oy)) * OW + int'(ox));
`ifdef CONV_RELU_EN
    result = mac_sum[AW-1] ? '0 : mac_sum;
`else
    result = mac_sum;
`endif
  end

  // Tap flags lag the address by one cycle to line up with the memories' read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      oc <= '0; oy <= '0; ox <= '0;
      ic <= '0; ky <= '0; kx <= '0;
      fm_addr  <= '0;
      wt_addr  <= '0;
      tap_pad  <= 1'b0;
      v_d      <= 1'b0;
      pad_d    <= 1'b0;
      first_d  <= 1'b0;
      out_data <= '0;
      out_addr <= '0;
    end else begin
      state <= n_state;
      oc <= n_oc; oy <= n_oy; ox <= n_ox;
      ic <= n_ic; ky <= n_ky; kx <= n_kx;
      if (load) begin
        wt_addr <= wt_next;
        tap_pad <= n_pad;
        if (!n_pad) fm_addr <= fm_next;
      end
      v_d     <= (state == S_MAC);
      pad_d   <= tap_pad;
      first_d <= (ic == '0) && (ky == '0) && (kx == '0);
      if (state == S_DRAIN) begin
        out_data <= result;
        out_addr <= pix_addr;
      end
    end
  end

  conv_mac #(.DW(DW), .WW(WW), .AW(AW)) u_mac (
    .clk       (clk),
    .rst       (rst),
    .tap_valid (v_d),
    .tap_first (first_d),
    .tap_pad   (pad_d),
    .fm_data   (fm_rdata),
    .wt_data   (wt_rdata),
    .sum       (mac_sum)
  );

endmodule

// File: tb/tb_conv2d_engine.sv
// Self-checking bench for conv2d_engine: padded, strided, multi-channel layer checked
// against a plain convolution model, with backpressure, reset and ReLU (CONV_RELU_EN) cases.
module tb_conv2d_engine;
  import conv_pkg::*;

  localparam int DW = 8, WW = 8, AW = 24;
  localparam int H = 5, W = 6, IC = 2, OC = 2, K = 3, STRIDE = 2, PAD = 1;
  localparam int OH = (H + 2 * PAD - K) / STRIDE + 1;
  localparam int OW = (W + 2 * PAD - K) / STRIDE + 1;
  localparam int NTAP = IC * K * K;
  localparam int NOUT = OC * OH * OW;
  localparam int FAW = addr_w(IC * H * W);
  localparam int WAW = addr_w(OC * IC * K * K);
  localparam int OAW = addr_w(NOUT);
  localparam int BUDGET = NOUT * (NTAP + 2) * 6 + 200;

  logic clk, rst, start, busy, done, out_valid, out_ready;
  logic [FAW-1:0] fm_addr;
  logic [WAW-1:0] wt_addr;
  logic [OAW-1:0] out_addr;
  logic signed [DW-1:0] fm_rdata;
  logic signed [WW-1:0] wt_rdata;
  logic signed [AW-1:0] out_data;

  logic signed [DW-1:0] fm_mem [IC*H*W];
  logic signed [WW-1:0] wt_mem [OC*IC*K*K];
  logic signed [AW-1:0] expv [NOUT];
  logic signed [AW-1:0] got  [NOUT];

  int vectors, miscompares, idx;
  logic check_en, prev_stall;
  logic signed [AW-1:0] prev_data;
  logic [OAW-1:0] prev_addr;
  logic [FAW-1:0] prev_fm;

  conv2d_engine #(
    .DW(DW), .WW(WW), .AW(AW), .H(H), .W(W), .IC(IC), .OC(OC),
    .K(K), .STRIDE(STRIDE), .PAD(PAD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .fm_addr(fm_addr), .fm_rdata(fm_rdata), .wt_addr(wt_addr), .wt_rdata(wt_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  // Synchronous memories with one cycle of read latency.
  always @(posedge clk) begin
    fm_rdata <= fm_mem[fm_addr];
    wt_rdata <= wt_mem[wt_addr];
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Straight textbook convolution over the bench's memories.
  function automatic void build_model();
    for (int o = 0; o < OC; o++)
      for (int y = 0; y < OH; y++)
        for (int x = 0; x < OW; x++) begin
          int acc = 0;
          for (int c = 0; c < IC; c++)
            for (int r = 0; r < K; r++)
              for (int s = 0; s < K; s++) begin
                int py = y * STRIDE + r - PAD;
                int px = x * STRIDE + s - PAD;
                if (py >= 0 && py < H && px >= 0 && px < W)
                  acc += int'(fm_mem[(c * H + py) * W + px]) * int'(wt_mem[((o * IC + c) * K + r) * K + s]);
              end
`ifdef CONV_RELU_EN
          if (acc < 0) acc = 0;
`endif
          expv[(o * OH + y) * OW + x] = AW'(acc);
        end
  endfunction

  // Result scoreboard plus stall-stability checks.
  always @(negedge clk) begin
    if (check_en && out_valid) begin
      if (prev_stall) begin
        checkOutput("stall_data_stable", int'(out_data), int'(prev_data));
        checkOutput("stall_addr_stable", int'(out_addr), int'(prev_addr));
        checkOutput("stall_fm_addr_frozen", int'(fm_addr), int'(prev_fm));
      end
      if (out_ready) begin
        if (idx < NOUT) begin
          checkOutput("result_data", int'(out_data), int'(expv[idx]));
          checkOutput("result_addr", int'(out_addr), idx);
          got[idx] = out_data;
        end else begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL extra_result: got result #%0d, expected only %0d", idx, NOUT);
        end
        idx++;
      end
      prev_stall = !out_ready;
      prev_data  = out_data;
      prev_addr  = out_addr;
      prev_fm    = fm_addr;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // kind 0: all ones; 1: weights -1; 2: stride pattern with centre one-hot weights; 3: random.
  task automatic applyStimulus(input int kind);
    for (int i = 0; i < IC * H * W; i++) begin
      case (kind)
        2:       fm_mem[i] = (i < H * W) ? DW'(i) : DW'(1);
        3:       fm_mem[i] = DW'($urandom_range(0, 255));
        default: fm_mem[i] = 8'sd1;
      endcase
    end
    for (int i = 0; i < OC * IC * K * K; i++) begin
      case (kind)
        1:       wt_mem[i] = -8'sd1;
        2:       wt_mem[i] = ((i % (IC * K * K)) == K + 1) ? 8'sd1 : 8'sd0;
        3:       wt_mem[i] = WW'($urandom_range(0, 255));
        default: wt_mem[i] = 8'sd1;
      endcase
    end
    build_model();
  endtask

  // rmode 0: ready held high; 1: random ready; 2: ten stall cycles on the first result.
  task automatic runLayer(input int rmode, input bit check_latency, input bit extra_start);
    int cyc = 0;
    int stall_left = 10;
    bit seen = 0;
    bit stall_checked = 0;
    idx = 0;
    prev_stall = 1'b0;
    check_en = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", int'(busy), 1);
    while (!done && cyc < BUDGET) begin
      start = extra_start && (cyc == 7);
      case (rmode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: if (out_valid && stall_left > 0) begin
             out_ready = 1'b0;
             stall_left--;
           end else begin
             if (out_valid && !stall_checked) begin
               stall_checked = 1;
               checkOutput("count_after_stall", idx, 0);
             end
             out_ready = 1'b1;
           end
        default: out_ready = 1'b1;
      endcase
      @(posedge clk); #1;
      cyc++;
      if (check_latency && !seen && out_valid) begin
        seen = 1;
        checkOutput("first_valid_latency", cyc, NTAP + 1);
      end
    end
    start = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL layer_timeout: got %0d results in %0d cycles, expected done", idx, cyc);
    end else begin
      checkOutput("busy_low_at_done", int'(busy), 0);
      checkOutput("result_count", idx, NOUT);
      @(posedge clk); #1;
      checkOutput("done_single_pulse", int'(done), 0);
    end
    check_en = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_out_data"}, int'(out_data), 0);
    checkOutput({tag, "_out_addr"}, int'(out_addr), 0);
    checkOutput({tag, "_fm_addr"}, int'(fm_addr), 0);
    checkOutput({tag, "_wt_addr"}, int'(wt_addr), 0);
  endtask

  initial begin
    clk = 0; rst = 1; start = 0; out_ready = 0; check_en = 0;
    vectors = 0; miscompares = 0; idx = 0; prev_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 0;
    @(posedge clk); #1;

    $display("[TB] all-ones layer with padding and stride");
    applyStimulus(0);
    checkOutput("model_corner", int'(expv[0]), 8);
    checkOutput("model_interior", int'(expv[4]), 18);
    runLayer(0, 1, 0);
    checkOutput("ones_corner", int'(got[0]), 8);
    checkOutput("ones_top_edge", int'(got[1]), 12);
    checkOutput("ones_interior", int'(got[4]), 18);
    checkOutput("ones_bottom_right", int'(got[8]), 12);

    $display("[TB] negative weights");
    applyStimulus(1);
    runLayer(0, 0, 0);
`ifdef CONV_RELU_EN
    checkOutput("relu_interior", int'(got[4]), 0);
`else
    checkOutput("raw_interior", int'(got[4]), -18);
`endif

    $display("[TB] stride pattern, centre tap");
    applyStimulus(2);
    runLayer(0, 0, 0);
    checkOutput("stride_mid", int'(got[4]), 14);
    checkOutput("stride_last", int'(got[8]), 28);
    checkOutput("stride_oc1_mid", int'(got[13]), 14);

    $display("[TB] random data with a ten-cycle stall");
    applyStimulus(3);
    runLayer(2, 0, 0);

    $display("[TB] random data, random ready, start while busy");
    applyStimulus(3);
    runLayer(1, 0, 1);

    $display("[TB] reset mid-MAC then restart");
    applyStimulus(3);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    checkResetState("midmac");
    rst = 0;
    runLayer(1, 0, 0);

    $display("[TB] reset and start together");
    rst = 1; start = 1;
    @(posedge clk); #1;
    rst = 0; start = 0;
    checkOutput("rst_start_busy", int'(busy), 0);
    @(posedge clk); #1;
    checkOutput("rst_start_still_idle", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
